distribute_in: RTL and testbench
================================

Name: distribute_in

Overview:
- Distribution stage between the per-input activation/weight READ engines and the per-lane MUL units.
- Takes NUM_DATA_INPUTS activation groups and one packed weight word, and routes them to NUM_DATA_OUTPUTS lanes.
- Each lane gets one activation group plus its own DATA_WIDTH weight slice, through a one-entry registered stage with valid/avail handshakes.
- Transfers per stream per configure are bounded to num_iters*num_reads_per_iter.

Parameters:
- NUM_DATA_INPUTS, 1, number of activation input ports.
- GROUP_SIZE, 2, data elements per activation group.
- DATA_WIDTH, 8, bits per element.
- NUM_DATA_OUTPUTS, 1, number of output lanes.
- LOG_MAX_ITERS, 4, width of num_iters.
- LOG_MAX_READS_PER_ITER, 8, width of num_reads_per_iter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- configure  in  1  one-cycle pulse; latches configuration and starts a run.
- conf_mode  in  1  1 = input i to lane i; 0 = broadcast input 0 to all lanes.
- num_iters  in  LOG_MAX_ITERS  iterations per run.
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  transfers per iteration.
- act_data_in  in  NUM_DATA_INPUTS*GROUP_SIZE*DATA_WIDTH  input i at bits [(i+1)*G*W-1 : i*G*W].
- act_valid_in  in  NUM_DATA_INPUTS  per-input valid.
- act_avail_out  out  NUM_DATA_INPUTS  per-input ready.
- weights_data_in  in  NUM_DATA_OUTPUTS*DATA_WIDTH  slice j belongs to lane j.
- weights_valid_in  in  1  weight word valid.
- weights_avail_out  out  1  weight ready.
- data_out  out  NUM_DATA_OUTPUTS*GROUP_SIZE*DATA_WIDTH  per-lane activation group.
- valid_out  out  NUM_DATA_OUTPUTS  per-lane activation valid.
- avail_in  in  NUM_DATA_OUTPUTS  per-lane downstream ready (activations).
- weights_data_out  out  NUM_DATA_OUTPUTS*DATA_WIDTH  per-lane weight.
- weights_valid_out  out  NUM_DATA_OUTPUTS  per-lane weight valid.
- weights_avail_in  in  NUM_DATA_OUTPUTS  per-lane downstream ready (weights).

Behaviour:
- Reset (rst=0, async):
  - All valid_out, weights_valid_out, act_avail_out and weights_avail_out = 0.
  - data_out and weights_data_out = 0.
  - Counters = 0; state IDLE.
- Configure:
  - On a clk edge with configure=1, latch conf_mode and total = num_iters*num_reads_per_iter (width LOG_MAX_ITERS+LOG_MAX_READS_PER_ITER).
  - Clear both stream counters and all output registers; go to RUN.
  - If total=0, stay IDLE.
  - configure has priority over any transfer in the same cycle, including mid-run.
- Handshakes:
  - Input transfer: valid && avail_out in the same cycle.
  - Output transfer: valid_out[j] && avail_in[j].
- Lane register j is "free" when it is empty, or when it is full and avail_in[j]=1.
- Activation, mode 1 (requires NUM_DATA_INPUTS = NUM_DATA_OUTPUTS):
  - act_avail_out[i] = RUN && act stream not done && lane i free.
  - On transfer, lane i register loads group i and valid_out[i]=1 the next cycle (latency 1).
  - Lanes are independent; one shared act counter increments on transfers of input 0.
- Activation, mode 0:
  - act_avail_out[0] = RUN && not done && all lanes free.
  - On transfer, every lane loads input 0 simultaneously.
  - act_avail_out[i>0] = 0.
- Weights:
  - weights_avail_out = RUN && weight stream not done && all weight lane registers free.
  - On transfer, lane j loads slice j and weights_valid_out[j]=1 the next cycle.
  - Weight counter increments per transfer.
- Output register release:
  - A full register whose output transfer occurs with no new load clears its valid the next cycle.
  - A simultaneous drain and load keeps valid=1 with the new data (full throughput, 1 transfer/cycle).
- Stream done when its counter = total; its avail_out then stays 0.
  - Registered data still drains normally.
- RUN goes to IDLE when both streams are done and all output registers are empty.
- Backpressure: while avail_in[j]=0, data_out/valid_out for lane j hold stable and the lane is not free.
- Width rules: no arithmetic on data; bits are passed unchanged.

Test Plan:
- Reset: hold rst=0 with random inputs → all valid/avail outputs 0 and data outputs 0; release, with no configure → avail outputs stay 0.
- Mode 1 pass-through:
  - Stimulus: 1 input/1 lane, num_iters=2, num_reads_per_iter=4, constant valids, avail_in=1, data sequence 0x0100..0x0107.
  - Response: each group appears on data_out one cycle after acceptance.
  - Response: exactly 8 act and 8 weight transfers, then act_avail_out=weights_avail_out=0 and state IDLE.
- Backpressure:
  - Stimulus: drop avail_in[0] two cycles after configure, hold it low 100 cycles, then raise it.
  - Response: data_out stable and valid_out=1 throughout; act_avail_out[0]=0; no loss or duplication after release; total still 8.
- Weight split: 2 lanes, weights_data_in=0xB2A1, one lane's weights_avail_in low → weights_avail_out=0 until both lanes are free; lane0 gets 0xA1, lane1 gets 0xB2.
- Broadcast mode 0: 1 input, 2 lanes, group 0x3344 → both lanes output 0x3344 in the same cycle; no transfer while either avail_in is low.
- Reconfigure mid-run: configure after 3 transfers with num_iters=1, num_reads_per_iter=2 → output registers cleared and exactly 2 further transfers per stream.

Source files
------------

// File: rtl/distribute_in.sv
// +---------------------------------------------------------------------------+
// | Module   : distribute_in                                                  |
// | Function : routes activation groups and weight slices to MUL lanes       |
// |            through one-entry registered stages with valid/avail handshake |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
`default_nettype none

module distribute_in #(
   parameter int NUM_DATA_INPUTS        = 1,
   parameter int GROUP_SIZE             = 2,
   parameter int DATA_WIDTH             = 8,
   parameter int NUM_DATA_OUTPUTS       = 1,
   parameter int LOG_MAX_ITERS          = 4,
   parameter int LOG_MAX_READS_PER_ITER = 8
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               configure,
   input  logic                                               conf_mode,
   input  logic [LOG_MAX_ITERS-1:0]                           num_iters,
   input  logic [LOG_MAX_READS_PER_ITER-1:0]                  num_reads_per_iter,
   input  logic [NUM_DATA_INPUTS*GROUP_SIZE*DATA_WIDTH-1:0]   act_data_in,
   input  logic [NUM_DATA_INPUTS-1:0]                         act_valid_in,
   output logic [NUM_DATA_INPUTS-1:0]                         act_avail_out,
   input  logic [NUM_DATA_OUTPUTS*DATA_WIDTH-1:0]             weights_data_in,
   input  logic                                               weights_valid_in,
   output logic                                               weights_avail_out,
   output logic [NUM_DATA_OUTPUTS*GROUP_SIZE*DATA_WIDTH-1:0]  data_out,
   output logic [NUM_DATA_OUTPUTS-1:0]                        valid_out,
   input  logic [NUM_DATA_OUTPUTS-1:0]                        avail_in,
   output logic [NUM_DATA_OUTPUTS*DATA_WIDTH-1:0]             weights_data_out,
   output logic [NUM_DATA_OUTPUTS-1:0]                        weights_valid_out,
   input  logic [NUM_DATA_OUTPUTS-1:0]                        weights_avail_in
);

   localparam int c_GW = GROUP_SIZE * DATA_WIDTH;
   localparam int c_TW = LOG_MAX_ITERS + LOG_MAX_READS_PER_ITER;

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_RUN  = 1'b1;

   localparam logic [c_TW-1:0] c_ONE = c_TW'(1);

   logic [0:0]                        r_state;
   logic                              r_mode;
   logic [c_TW-1:0]                   r_total;
   logic [c_TW-1:0]                   r_act_cnt;
   logic [c_TW-1:0]                   r_wt_cnt;
   logic [NUM_DATA_OUTPUTS-1:0]       r_valid;
   logic [NUM_DATA_OUTPUTS-1:0]       r_wvalid;
   logic [NUM_DATA_OUTPUTS*c_GW-1:0]  r_data;
   logic [NUM_DATA_OUTPUTS*DATA_WIDTH-1:0] r_wdata;

   logic                              w_run;
   logic                              w_act_done;
   logic                              w_wt_done;
   logic [NUM_DATA_OUTPUTS-1:0]       w_free;
   logic [NUM_DATA_OUTPUTS-1:0]       w_wfree;
   logic                              w_all_free;
   logic                              w_all_wfree;
   logic                              w_act0_xfer;
   logic                              w_wt_load;
   logic [NUM_DATA_OUTPUTS-1:0]       w_act_load;
   logic [NUM_DATA_OUTPUTS*c_GW-1:0]  w_act_src;
   logic [c_TW-1:0]                   w_new_total;
   logic                              w_lanes_empty;

   assign w_new_total   = c_TW'(num_iters) * c_TW'(num_reads_per_iter);
   assign w_run         = (r_state == c_RUN);
   assign w_act_done    = (r_act_cnt == r_total);
   assign w_wt_done     = (r_wt_cnt == r_total);
   assign w_lanes_empty = ~(|r_valid) & ~(|r_wvalid);

   // A lane can accept when empty, or when its current word leaves this cycle.
   assign w_free      = ~r_valid  | avail_in;
   assign w_wfree     = ~r_wvalid | weights_avail_in;
   assign w_all_free  = &w_free;
   assign w_all_wfree = &w_wfree;

   assign w_act0_xfer       = act_valid_in[0] & act_avail_out[0];
   assign weights_avail_out = w_run & ~w_wt_done & w_all_wfree;
   assign w_wt_load         = weights_valid_in & weights_avail_out;

   generate
      for (genvar i = 0; i < NUM_DATA_INPUTS; i++) begin : g_act_avail
         if (i == 0) begin : g_in0
            assign act_avail_out[i] = w_run & ~w_act_done & (r_mode ? w_free[0] : w_all_free);
         end else if (i < NUM_DATA_OUTPUTS) begin : g_own
            assign act_avail_out[i] = w_run & ~w_act_done & r_mode & w_free[i];
         end else begin : g_none
            assign act_avail_out[i] = 1'b0;
         end
      end

      for (genvar j = 0; j < NUM_DATA_OUTPUTS; j++) begin : g_lane_src
         if (j < NUM_DATA_INPUTS) begin : g_own
            assign w_act_load[j] = r_mode ? (act_valid_in[j] & act_avail_out[j]) : w_act0_xfer;
            assign w_act_src[j*c_GW +: c_GW] = r_mode ? act_data_in[j*c_GW +: c_GW]
                                                      : act_data_in[0 +: c_GW];
         end else begin : g_bcast
            assign w_act_load[j] = ~r_mode & w_act0_xfer;
            assign w_act_src[j*c_GW +: c_GW] = act_data_in[0 +: c_GW];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= c_IDLE;
         r_mode    <= 1'b0;
         r_total   <= '0;
         r_act_cnt <= '0;
         r_wt_cnt  <= '0;
      end else if (configure) begin
         r_mode    <= conf_mode;
         r_total   <= w_new_total;
         r_act_cnt <= '0;
         r_wt_cnt  <= '0;
         r_state   <= (w_new_total == '0) ? c_IDLE : c_RUN;
      end else begin
         if (w_act0_xfer) begin
            r_act_cnt <= r_act_cnt + c_ONE;
         end
         if (w_wt_load) begin
            r_wt_cnt <= r_wt_cnt + c_ONE;
         end
         if (w_run && w_act_done && w_wt_done && w_lanes_empty) begin
            r_state <= c_IDLE;
         end
      end
   end

   // A load wins over a drain so back-to-back transfers keep valid high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid  <= '0;
         r_wvalid <= '0;
         r_data   <= '0;
         r_wdata  <= '0;
      end else if (configure) begin
         r_valid  <= '0;
         r_wvalid <= '0;
         r_data   <= '0;
         r_wdata  <= '0;
      end else begin
         for (int j = 0; j < NUM_DATA_OUTPUTS; j++) begin
            if (w_act_load[j]) begin
               r_valid[j]                <= 1'b1;
               r_data[j*c_GW +: c_GW]    <= w_act_src[j*c_GW +: c_GW];
            end else if (avail_in[j]) begin
               r_valid[j]                <= 1'b0;
            end
            if (w_wt_load) begin
               r_wvalid[j]                         <= 1'b1;
               r_wdata[j*DATA_WIDTH +: DATA_WIDTH] <= weights_data_in[j*DATA_WIDTH +: DATA_WIDTH];
            end else if (weights_avail_in[j]) begin
               r_wvalid[j]                         <= 1'b0;
            end
         end
      end
   end

   assign data_out          = r_data;
   assign valid_out         = r_valid;
   assign weights_data_out  = r_wdata;
   assign weights_valid_out = r_wvalid;

endmodule

`default_nettype wire

// File: tb/tb_distribute_in.sv
// +---------------------------------------------------------------------------+
// | Module   : tb_distribute_in                                               |
// | Function : directed vector bench for distribute_in (2 inputs, 2 lanes)   |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_distribute_in;

   logic        clk = 1'b0;
   logic        rst;
   logic        configure;
   logic        conf_mode;
   logic [3:0]  num_iters;
   logic [7:0]  num_reads_per_iter;
   logic [31:0] act_data_in;
   logic [1:0]  act_valid_in;
   logic [1:0]  act_avail_out;
   logic [15:0] weights_data_in;
   logic        weights_valid_in;
   logic        weights_avail_out;
   logic [31:0] data_out;
   logic [1:0]  valid_out;
   logic [1:0]  avail_in;
   logic [15:0] weights_data_out;
   logic [1:0]  weights_valid_out;
   logic [1:0]  weights_avail_in;

   distribute_in #(
      .NUM_DATA_INPUTS        (2),
      .GROUP_SIZE             (2),
      .DATA_WIDTH             (8),
      .NUM_DATA_OUTPUTS       (2),
      .LOG_MAX_ITERS          (4),
      .LOG_MAX_READS_PER_ITER (8)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .configure          (configure),
      .conf_mode          (conf_mode),
      .num_iters          (num_iters),
      .num_reads_per_iter (num_reads_per_iter),
      .act_data_in        (act_data_in),
      .act_valid_in       (act_valid_in),
      .act_avail_out      (act_avail_out),
      .weights_data_in    (weights_data_in),
      .weights_valid_in   (weights_valid_in),
      .weights_avail_out  (weights_avail_out),
      .data_out           (data_out),
      .valid_out          (valid_out),
      .avail_in           (avail_in),
      .weights_data_out   (weights_data_out),
      .weights_valid_out  (weights_valid_out),
      .weights_avail_in   (weights_avail_in)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        cfg;
      logic        mode;
      logic [3:0]  iters;
      logic [7:0]  reads;
      logic [31:0] act_data;
      logic [1:0]  act_valid;
      logic [15:0] wdata;
      logic        wvalid;
      logic [1:0]  av_in;
      logic [1:0]  wav_in;
      logic [1:0]  e_act_avail;
      logic        e_w_avail;
      logic [1:0]  e_valid;
      logic [31:0] e_data;
      logic [31:0] m_data;
      logic [1:0]  e_wvalid;
      logic [15:0] e_wdata;
      logic [15:0] m_wdata;
   } vec_t;

   vec_t vecs[$];
   vec_t v;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic vin(input logic cfg, input logic mode, input logic [3:0] it, input logic [7:0] rd,
                      input logic [31:0] ad, input logic [1:0] av, input logic [15:0] wd,
                      input logic wv, input logic [1:0] ai, input logic [1:0] wai);
      v.cfg = cfg; v.mode = mode; v.iters = it; v.reads = rd;
      v.act_data = ad; v.act_valid = av; v.wdata = wd; v.wvalid = wv;
      v.av_in = ai; v.wav_in = wai;
   endtask

   task automatic vexp(input logic [1:0] ea, input logic ew, input logic [1:0] evo,
                       input logic [31:0] ed, input logic [31:0] md, input logic [1:0] ewvo,
                       input logic [15:0] ewd, input logic [15:0] mwd);
      v.e_act_avail = ea; v.e_w_avail = ew; v.e_valid = evo; v.e_data = ed; v.m_data = md;
      v.e_wvalid = ewvo; v.e_wdata = ewd; v.m_wdata = mwd;
      vecs.push_back(v);
   endtask

   initial begin
      int n_in;
      int n_out;
      int hold_err;

      // ---------------- vector table ----------------
      // mode 1 pass-through, 2x4 = 8 transfers per stream
      vin(1'b1, 1'b1, 4'd2, 8'd4, 32'hEE00_00FF, 2'b01, 16'h0, 1'b1, 2'b11, 2'b11);
      vexp(2'b00, 1'b0, 2'b00, 32'h0, 32'hFFFF_FFFF, 2'b00, 16'h0, 16'hFFFF);
      for (int k = 0; k < 8; k++) begin
         vin(1'b0, 1'b1, 4'd2, 8'd4, {16'(16'hEE00 + k), 16'(16'h0100 + k)}, 2'b01,
             {8'(8'hB0 + k), 8'(8'hA0 + k)}, 1'b1, 2'b11, 2'b11);
         vexp(2'b11, 1'b1, 2'b01, {16'h0000, 16'(16'h0100 + k)}, 32'hFFFF_FFFF,
              2'b11, {8'(8'hB0 + k), 8'(8'hA0 + k)}, 16'hFFFF);
      end
      for (int k = 0; k < 2; k++) begin
         vin(1'b0, 1'b1, 4'd2, 8'd4, 32'hEE08_0108, 2'b01, 16'hB8A8, 1'b1, 2'b11, 2'b11);
         vexp(2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 16'h0, 16'h0);
      end
      // weight split with lane 1 stalled
      vin(1'b1, 1'b1, 4'd1, 8'd2, 32'h0, 2'b00, 16'h0, 1'b0, 2'b11, 2'b11);
      vexp(2'b00, 1'b0, 2'b00, 32'h0, 32'hFFFF_FFFF, 2'b00, 16'h0, 16'hFFFF);
      vin(1'b0, 1'b1, 4'd1, 8'd2, 32'h0, 2'b00, 16'hB2A1, 1'b1, 2'b11, 2'b01);
      vexp(2'b11, 1'b1, 2'b00, 32'h0, 32'hFFFF_FFFF, 2'b11, 16'hB2A1, 16'hFFFF);
      vin(1'b0, 1'b1, 4'd1, 8'd2, 32'h0, 2'b00, 16'hD4C3, 1'b1, 2'b11, 2'b01);
      vexp(2'b11, 1'b0, 2'b00, 32'h0, 32'hFFFF_FFFF, 2'b10, 16'hB200, 16'hFF00);
      vin(1'b0, 1'b1, 4'd1, 8'd2, 32'h0, 2'b00, 16'hD4C3, 1'b1, 2'b11, 2'b11);
      vexp(2'b11, 1'b1, 2'b00, 32'h0, 32'hFFFF_FFFF, 2'b11, 16'hD4C3, 16'hFFFF);
      vin(1'b0, 1'b1, 4'd1, 8'd2, 32'h0, 2'b00, 16'hE5E5, 1'b1, 2'b11, 2'b11);
      vexp(2'b11, 1'b0, 2'b00, 32'h0, 32'hFFFF_FFFF, 2'b00, 16'h0, 16'h0);
      // broadcast mode 0
      vin(1'b1, 1'b0, 4'd1, 8'd2, 32'h9999_3344, 2'b01, 16'h0, 1'b0, 2'b11, 2'b11);
      vexp(2'b11, 1'b0, 2'b00, 32'h0, 32'hFFFF_FFFF, 2'b00, 16'h0, 16'hFFFF);
      vin(1'b0, 1'b0, 4'd1, 8'd2, 32'h9999_3344, 2'b01, 16'h0, 1'b0, 2'b11, 2'b11);
      vexp(2'b01, 1'b1, 2'b11, 32'h3344_3344, 32'hFFFF_FFFF, 2'b00, 16'h0, 16'hFFFF);
      vin(1'b0, 1'b0, 4'd1, 8'd2, 32'h9999_5566, 2'b01, 16'h0, 1'b0, 2'b10, 2'b11);
      vexp(2'b00, 1'b1, 2'b01, 32'h0000_3344, 32'h0000_FFFF, 2'b00, 16'h0, 16'hFFFF);
      vin(1'b0, 1'b0, 4'd1, 8'd2, 32'h9999_5566, 2'b01, 16'h0, 1'b0, 2'b11, 2'b11);
      vexp(2'b01, 1'b1, 2'b11, 32'h5566_5566, 32'hFFFF_FFFF, 2'b00, 16'h0, 16'hFFFF);
      vin(1'b0, 1'b0, 4'd1, 8'd2, 32'h9999_5566, 2'b01, 16'h0, 1'b0, 2'b11, 2'b11);
      vexp(2'b00, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 16'h0, 16'hFFFF);
      // reconfigure mid-run, then a zero-length configure
      vin(1'b1, 1'b1, 4'd2, 8'd4, 32'h0000_0700, 2'b01, 16'h7000, 1'b1, 2'b11, 2'b11);
      vexp(2'b00, 1'b1, 2'b00, 32'h0, 32'hFFFF_FFFF, 2'b00, 16'h0, 16'hFFFF);
      for (int k = 0; k < 3; k++) begin
         vin(1'b0, 1'b1, 4'd2, 8'd4, {16'h0, 16'(16'h0700 + k)}, 2'b01, 16'(16'h7000 + k), 1'b1, 2'b11, 2'b11);
         vexp(2'b11, 1'b1, 2'b01, {16'h0, 16'(16'h0700 + k)}, 32'hFFFF_FFFF, 2'b11, 16'(16'h7000 + k), 16'hFFFF);
      end
      vin(1'b1, 1'b1, 4'd1, 8'd2, 32'h0000_0703, 2'b01, 16'h7003, 1'b1, 2'b11, 2'b11);
      vexp(2'b11, 1'b1, 2'b00, 32'h0, 32'hFFFF_FFFF, 2'b00, 16'h0, 16'hFFFF);
      for (int k = 0; k < 2; k++) begin
         vin(1'b0, 1'b1, 4'd1, 8'd2, {16'h0, 16'(16'h0800 + k)}, 2'b01, 16'(16'h8000 + k), 1'b1, 2'b11, 2'b11);
         vexp(2'b11, 1'b1, 2'b01, {16'h0, 16'(16'h0800 + k)}, 32'hFFFF_FFFF, 2'b11, 16'(16'h8000 + k), 16'hFFFF);
      end
      vin(1'b0, 1'b1, 4'd1, 8'd2, 32'h0000_0802, 2'b01, 16'h8002, 1'b1, 2'b11, 2'b11);
      vexp(2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 16'h0, 16'h0);
      vin(1'b1, 1'b1, 4'd0, 8'd5, 32'h0000_0803, 2'b01, 16'h8003, 1'b1, 2'b11, 2'b11);
      vexp(2'b00, 1'b0, 2'b00, 32'h0, 32'hFFFF_FFFF, 2'b00, 16'h0, 16'hFFFF);
      vin(1'b0, 1'b1, 4'd0, 8'd5, 32'h0000_0804, 2'b01, 16'h8004, 1'b1, 2'b11, 2'b11);
      vexp(2'b00, 1'b0, 2'b00, 32'h0, 32'hFFFF_FFFF, 2'b00, 16'h0, 16'hFFFF);

      // ---------------- reset ----------------
      rst                = 1'b0;
      configure          = 1'($urandom);
      conf_mode          = 1'($urandom);
      num_iters          = 4'($urandom);
      num_reads_per_iter = 8'($urandom);
      act_data_in        = $urandom;
      act_valid_in       = 2'($urandom);
      weights_data_in    = 16'($urandom);
      weights_valid_in   = 1'($urandom);
      avail_in           = 2'($urandom);
      weights_avail_in   = 2'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check("rst valid_out", 32'(valid_out), 32'h0);
      check("rst weights_valid_out", 32'(weights_valid_out), 32'h0);
      check("rst act_avail_out", 32'(act_avail_out), 32'h0);
      check("rst weights_avail_out", 32'(weights_avail_out), 32'h0);
      check("rst data_out", data_out, 32'h0);
      check("rst weights_data_out", 32'(weights_data_out), 32'h0);

      configure        = 1'b0;
      act_valid_in     = 2'b11;
      weights_valid_in = 1'b1;
      avail_in         = 2'b11;
      weights_avail_in = 2'b11;
      rst              = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle act_avail_out", 32'(act_avail_out), 32'h0);
      check("idle weights_avail_out", 32'(weights_avail_out), 32'h0);
      check("idle valid_out", 32'(valid_out), 32'h0);
      check("idle weights_valid_out", 32'(weights_valid_out), 32'h0);

      // ---------------- apply table ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         configure          = vecs[i].cfg;
         conf_mode          = vecs[i].mode;
         num_iters          = vecs[i].iters;
         num_reads_per_iter = vecs[i].reads;
         act_data_in        = vecs[i].act_data;
         act_valid_in       = vecs[i].act_valid;
         weights_data_in    = vecs[i].wdata;
         weights_valid_in   = vecs[i].wvalid;
         avail_in           = vecs[i].av_in;
         weights_avail_in   = vecs[i].wav_in;
         #1;
         check($sformatf("v%0d act_avail_out", i), 32'(act_avail_out), 32'(vecs[i].e_act_avail));
         check($sformatf("v%0d weights_avail_out", i), 32'(weights_avail_out), 32'(vecs[i].e_w_avail));
         @(posedge clk);
         #1;
         check($sformatf("v%0d valid_out", i), 32'(valid_out), 32'(vecs[i].e_valid));
         check($sformatf("v%0d data_out", i), data_out & vecs[i].m_data, vecs[i].e_data & vecs[i].m_data);
         check($sformatf("v%0d weights_valid_out", i), 32'(weights_valid_out), 32'(vecs[i].e_wvalid));
         check($sformatf("v%0d weights_data_out", i), 32'(weights_data_out & vecs[i].m_wdata),
               32'(vecs[i].e_wdata & vecs[i].m_wdata));
      end

      // ---------------- long backpressure on lane 0 ----------------
      configure          = 1'b1;
      conf_mode          = 1'b1;
      num_iters          = 4'd2;
      num_reads_per_iter = 8'd4;
      act_valid_in       = 2'b01;
      act_data_in        = 32'h0000_0200;
      weights_valid_in   = 1'b1;
      weights_avail_in   = 2'b11;
      avail_in           = 2'b11;
      @(posedge clk);
      #1;
      configure = 1'b0;
      n_in      = 0;
      n_out     = 0;
      hold_err  = 0;
      for (int c = 0; c < 140; c++) begin
         act_data_in     = {16'h0, 16'(16'h0200 + n_in)};
         weights_data_in = 16'(c);
         avail_in        = {1'b1, !(c >= 2 && c < 102)};
         #1;
         if (c >= 2 && c < 102) begin
            if (valid_out[0] !== 1'b1 || data_out[15:0] !== 16'(16'h0200 + n_out) ||
                act_avail_out[0] !== 1'b0)
               hold_err++;
         end
         if (valid_out[0] && avail_in[0]) begin
            check($sformatf("bp out %0d", n_out), 32'(data_out[15:0]), 32'(16'h0200 + n_out));
            n_out++;
         end
         if (act_valid_in[0] && act_avail_out[0]) n_in++;
         @(posedge clk);
         #1;
      end
      check("bp hold stable", 32'(hold_err), 32'h0);
      check("bp out count", 32'(n_out), 32'd8);
      check("bp in count", 32'(n_in), 32'd8);
      check("bp final act_avail_out", 32'(act_avail_out), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
